// File: rtl/display_pkg.sv
// Shared constants, types and the double-dabble digit adjust for the display front end.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned CODE_W     = 5;
  localparam int unsigned VALUE_W    = 14;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
  localparam int unsigned MSG_W      = NUM_DIGITS * CODE_W;
  localparam int unsigned DD_ITERS   = VALUE_W;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [CODE_W-1:0] CODE_E     = CODE_W'(14);
  localparam logic [CODE_W-1:0] CODE_R     = CODE_W'(15);
  localparam logic [CODE_W-1:0] CODE_MINUS = CODE_W'(22);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] digits_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// Content-load request and scan outputs between the host side and display_scan.
interface display_scan_if;
  import display_pkg::*;

  logic                  load;
  logic [VALUE_W-1:0]    value;
  logic                  neg;
  logic                  msg_en;
  logic [MSG_W-1:0]      msg;
  logic                  busy;
  logic [CODE_W-1:0]     code;
  logic [NUM_DIGITS-1:0] an;

  modport master (output load, value, neg, msg_en, msg, input busy, code, an);
  modport slave  (input load, value, neg, msg_en, msg, output busy, code, an);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, first shift taken on the start edge.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  localparam int unsigned CNT_W = $clog2(DD_ITERS + 1);

  logic [VALUE_W-1:0] bin_q,    bin_d;
  logic [BCD_W-1:0]   bcd_q,    bcd_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               active_q, active_d;
  logic               done_q,   done_d;
  logic [BCD_W+VALUE_W-1:0] shifted;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // done pulses in the cycle after the last shift so the caller can commit next edge.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    shifted  = {dd_adjust(bcd_q), bin_q} << 1;
    if (start_i) begin
      bcd_d    = BCD_W'(value_i[VALUE_W-1]);
      bin_d    = {value_i[VALUE_W-2:0], 1'b0};
      cnt_d    = CNT_W'(1);
      active_d = 1'b1;
    end else if (active_q) begin
      {bcd_d, bin_d} = shifted;
      cnt_d          = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DD_ITERS - 1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  assign busy_o = active_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/display_scan.sv
// Four-digit seven-segment front end: content FSM, number formatting and digit scan.
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic           clk,
  input  logic           rst_n,
  display_scan_if.slave  bus
);

  localparam int unsigned RCNT_W = $clog2(REFRESH_DIV);

  state_e                state_q,    state_d;
  logic [VALUE_W-1:0]    value_q,    value_d;
  logic                  neg_q,      neg_d;
  logic                  msg_mode_q, msg_mode_d;
  digits_t               msg_q,      msg_d;
  digits_t               digits_q,   digits_d;
  logic [NUM_DIGITS-1:0] blank_q,    blank_d;
  logic [RCNT_W-1:0]     rcnt_q,     rcnt_d;
  logic [IDX_W-1:0]      idx_q,      idx_d;

  logic                  eng_start;
  logic                  eng_busy;
  logic                  eng_done;
  logic [BCD_W-1:0]      eng_bcd;
  digits_t               fmt_digits;
  logic [NUM_DIGITS-1:0] fmt_blank;
  logic [IDX_W-1:0]      msd;
  logic                  lead;
  logic                  is_err;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (eng_start),
    .value_i (bus.value),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .bcd_o   (eng_bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      neg_q      <= 1'b0;
      msg_mode_q <= 1'b0;
      msg_q      <= '0;
      digits_q   <= '0;
      blank_q    <= NUM_DIGITS'(4'b1110);
      rcnt_q     <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      neg_q      <= neg_d;
      msg_mode_q <= msg_mode_d;
      msg_q      <= msg_d;
      digits_q   <= digits_d;
      blank_q    <= blank_d;
      rcnt_q     <= rcnt_d;
      idx_q      <= idx_d;
    end
  end

  // Content FSM; digits and blank mask only change together in COMMIT.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    neg_d      = neg_q;
    msg_mode_d = msg_mode_q;
    msg_d      = msg_q;
    digits_d   = digits_q;
    blank_d    = blank_q;
    eng_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          if (bus.msg_en) begin
            msg_d      = bus.msg;
            msg_mode_d = 1'b1;
            state_d    = ST_COMMIT;
          end else if (!eng_busy) begin
            value_d    = bus.value;
            neg_d      = bus.neg;
            msg_mode_d = 1'b0;
            eng_start  = 1'b1;
            state_d    = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        if (eng_done) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        digits_d = msg_mode_q ? msg_q : fmt_digits;
        blank_d  = msg_mode_q ? '0 : fmt_blank;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Numeric formatting: error text, sign placement and leading-zero blanking.
  always_comb begin
    fmt_digits = '0;
    fmt_blank  = '0;
    msd        = '0;
    lead       = 1'b1;
    is_err     = neg_q ? (value_q > VALUE_W'(999)) : (value_q > VALUE_W'(9999));
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      fmt_digits[i] = CODE_W'(eng_bcd[4*i +: 4]);
    end
    if (is_err) begin
      fmt_digits = {CODE_E, CODE_R, CODE_R, CODE_W'(0)};
      fmt_blank  = NUM_DIGITS'(4'b0001);
    end else if (neg_q && value_q == '0) begin
      fmt_blank = NUM_DIGITS'(4'b1110);
    end else if (neg_q) begin
      for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
        if (eng_bcd[4*i +: 4] != 4'd0) msd = IDX_W'(i);
      end
      fmt_digits[msd + IDX_W'(1)] = CODE_MINUS;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (i > 32'(msd) + 32'd1) fmt_blank[i] = 1'b1;
      end
    end else begin
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        lead         = lead && (eng_bcd[4*i +: 4] == 4'd0);
        fmt_blank[i] = lead;
      end
    end
  end

  // Free-running scan: hold each digit REFRESH_DIV cycles, walk 3,2,1,0.
  always_comb begin
    rcnt_d = rcnt_q + RCNT_W'(1);
    idx_d  = idx_q;
    if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      idx_d  = idx_q - IDX_W'(1);
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.code = digits_q[idx_q];
  assign bus.an   = blank_q[idx_q] ? '1 : ~(NUM_DIGITS'(1) << idx_q);

endmodule

// File: tb/tb_display_scan.sv
// Randomized and directed bench for display_scan against a behavioural display model.
module tb_display_scan;
  import display_pkg::*;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  display_scan_if bus ();

  display_scan #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model state: edges since reset, remaining busy cycles, shown and pending content.
  int               m_t;
  int               m_busy;
  logic [3:0][4:0]  m_dig, m_pdig;
  logic [3:0]       m_blank, m_pblank;

  logic             chk_en = 1'b0;
  logic             lit_on = 1'b0;
  int               lit_busy_len = 0;
  logic [3:0]       lit_an   [4];
  logic [4:0]       lit_code [4];
  bit               pinned = 1'b0;
  int               brun = 0;

  function automatic void fmt_num(input int v, input bit n,
                                  output logic [3:0][4:0] d, output logic [3:0] b);
    int nd;
    d = '0;
    b = '0;
    if ((!n && v > 9999) || (n && v > 999)) begin
      d[3] = 5'd14; d[2] = 5'd15; d[1] = 5'd15;
      b = 4'b0001;
      return;
    end
    d[0] = 5'(v % 10);
    d[1] = 5'((v / 10) % 10);
    d[2] = 5'((v / 100) % 10);
    d[3] = 5'((v / 1000) % 10);
    nd = (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
    if (n && v != 0) begin
      d[nd] = 5'd22;
      for (int i = nd + 1; i < 4; i++) b[i] = 1'b1;
    end else begin
      for (int i = nd; i < 4; i++) b[i] = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_t     = 0;
      m_busy  = 0;
      m_dig   = '0;
      m_blank = 4'b1110;
    end else begin
      m_t = m_t + 1;
      if (m_busy > 0) begin
        m_busy = m_busy - 1;
        if (m_busy == 0) begin
          m_dig   = m_pdig;
          m_blank = m_pblank;
        end
      end else if (bus.load) begin
        if (bus.msg_en) begin
          m_pdig   = bus.msg;
          m_pblank = '0;
          m_busy   = 1;
        end else begin
          fmt_num(int'(bus.value), bus.neg, m_pdig, m_pblank);
          m_busy = 15;
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      fails = fails + 1;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
    end
  endtask

  // Single compare process: model pins, per-cycle model check, literal frames, busy length.
  always @(negedge clk) begin
    int idx;
    logic [3:0] exp_an;
    logic [3:0][4:0] pd;
    logic [3:0] pb;
    if (chk_en) begin
      if (!pinned) begin
        pinned = 1'b1;
        fmt_num(42, 1'b1, pd, pb);
        chk("pin42_d2", int'(pd[2]), 22);
        chk("pin42_d1", int'(pd[1]), 4);
        chk("pin42_d0", int'(pd[0]), 2);
        chk("pin42_b", int'(pb), 8);
        fmt_num(0, 1'b1, pd, pb);
        chk("pin_neg0_b", int'(pb), 14);
        fmt_num(305, 1'b0, pd, pb);
        chk("pin305_b", int'(pb), 8);
        chk("pin305_d1", int'(pd[1]), 0);
        fmt_num(9999, 1'b0, pd, pb);
        chk("pin9999_b", int'(pb), 0);
        fmt_num(1000, 1'b1, pd, pb);
        chk("pin_err_d3", int'(pd[3]), 14);
        chk("pin_err_b", int'(pb), 1);
      end
      idx    = (4 - ((m_t / DIV) % 4)) % 4;
      exp_an = m_blank[idx] ? 4'hF : ~(4'b0001 << idx);
      chk("busy", int'(bus.busy), int'(m_busy > 0));
      chk("an", int'(bus.an), int'(exp_an));
      if (!m_blank[idx]) chk("code", int'(bus.code), int'(m_dig[idx]));
      if (lit_on) begin
        chk("lit_an", int'(bus.an), int'(lit_an[idx]));
        if (lit_an[idx] != 4'hF) chk("lit_code", int'(bus.code), int'(lit_code[idx]));
      end
      if (bus.busy === 1'b1) begin
        brun = brun + 1;
      end else begin
        if (brun != 0 && lit_busy_len != 0) chk("busy_len", brun, lit_busy_len);
        brun = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int v, input bit n, input bit me, input logic [19:0] m);
    @(negedge clk);
    bus.load   = 1'b1;
    bus.value  = 14'(v);
    bus.neg    = n;
    bus.msg_en = me;
    bus.msg    = m;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic set_lit(input logic [3:0] a3, input logic [4:0] c3,
                         input logic [3:0] a2, input logic [4:0] c2,
                         input logic [3:0] a1, input logic [4:0] c1,
                         input logic [3:0] a0, input logic [4:0] c0);
    lit_an[3] = a3; lit_code[3] = c3;
    lit_an[2] = a2; lit_code[2] = c2;
    lit_an[1] = a1; lit_code[1] = c1;
    lit_an[0] = a0; lit_code[0] = c0;
  endtask

  task automatic lit_frame();
    lit_on = 1'b1;
    cyc(4 * DIV);
    lit_on = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, v;
    rst_n      = 1'b0;
    bus.load   = 1'b0;
    bus.value  = '0;
    bus.neg    = 1'b0;
    bus.msg_en = 1'b0;
    bus.msg    = '0;
    cyc(2);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    set_lit(4'hF, 5'd0, 4'hF, 5'd0, 4'hF, 5'd0, 4'b1110, 5'd0);
    lit_frame();

    lit_busy_len = 15;
    do_load(1234, 1'b0, 1'b0, 20'd0);
    cyc(16);
    set_lit(4'b0111, 5'd1, 4'b1011, 5'd2, 4'b1101, 5'd3, 4'b1110, 5'd4);
    lit_frame();

    do_load(42, 1'b1, 1'b0, 20'd0);
    cyc(16);
    set_lit(4'hF, 5'd0, 4'b1011, 5'd22, 4'b1101, 5'd4, 4'b1110, 5'd2);
    lit_frame();

    set_lit(4'b0111, 5'd14, 4'b1011, 5'd15, 4'b1101, 5'd15, 4'hF, 5'd0);
    do_load(10000, 1'b0, 1'b0, 20'd0);
    cyc(16);
    lit_frame();
    do_load(1000, 1'b1, 1'b0, 20'd0);
    cyc(16);
    lit_frame();

    lit_busy_len = 1;
    @(negedge clk);
    bus.load = 1'b1; bus.msg_en = 1'b1; bus.msg = {5'd16, 5'd17, 5'd18, 5'd19};
    @(negedge clk);
    bus.msg = {5'd1, 5'd2, 5'd3, 5'd4};
    @(negedge clk);
    bus.load = 1'b0; bus.msg_en = 1'b0;
    cyc(2);
    set_lit(4'b0111, 5'd16, 4'b1011, 5'd17, 4'b1101, 5'd18, 4'b1110, 5'd19);
    lit_frame();

    lit_busy_len = 0;
    do_load(9999, 1'b0, 1'b0, 20'd0);
    cyc(6);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_lit(4'hF, 5'd0, 4'hF, 5'd0, 4'hF, 5'd0, 4'b1110, 5'd0);
    lit_frame();

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 4));
      case (r)
        0: v = int'($urandom_range(0, 9999));
        1: v = int'($urandom_range(0, 999));
        2: v = 995 + int'($urandom_range(0, 10));
        3: v = 9995 + int'($urandom_range(0, 10));
        default: v = int'($urandom_range(0, 16383));
      endcase
      do_load(v, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 20'($urandom));
      cyc(int'($urandom_range(0, 24)));
    end
    cyc(4 * DIV + 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
